keypad_scanner: RTL

//  Front end for the PIN-entry lock: drives a 4x4 matrix keypad column by column and

---
 rtl/keypad_pkg.sv | 38 +++
 rtl/keypad_sync.sv | 27 ++
 rtl/keypad_scanner.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/keypad_pkg.sv
// Shared types and key codes for the 4x4 keypad front end and the PIN-entry lock.
package keypad_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DEBOUNCE = 2'd1,
        PRESSED  = 2'd2,
        RELEASE  = 2'd3
    } kp_state_t;

    typedef enum logic [1:0] {
        SCAN_NONE   = 2'd0,
        SCAN_SINGLE = 2'd1,
        SCAN_MULTI  = 2'd2
    } scan_kind_t;

    localparam logic [3:0] KEY_0 = 4'h0;
    localparam logic [3:0] KEY_1 = 4'h1;
    localparam logic [3:0] KEY_2 = 4'h2;
    localparam logic [3:0] KEY_3 = 4'h3;
    localparam logic [3:0] KEY_4 = 4'h4;
    localparam logic [3:0] KEY_5 = 4'h5;
    localparam logic [3:0] KEY_6 = 4'h6;
    localparam logic [3:0] KEY_7 = 4'h7;
    localparam logic [3:0] KEY_8 = 4'h8;
    localparam logic [3:0] KEY_9 = 4'h9;
    localparam logic [3:0] KEY_A = 4'hA;
    localparam logic [3:0] KEY_B = 4'hB;
    localparam logic [3:0] KEY_C = 4'hC;
    localparam logic [3:0] KEY_D = 4'hD;
    localparam logic [3:0] KEY_E = 4'hE;
    localparam logic [3:0] KEY_F = 4'hF;

    function automatic logic [3:0] row_col_to_code(input logic [1:0] row, input logic [1:0] col);
        return {row, col};
    endfunction

endpackage

// File: rtl/keypad_sync.sv
// Two-flop synchroniser for the asynchronous row returns; idles at all-ones (no key).
module keypad_sync #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] i_async,
    output logic [WIDTH-1:0] o_sync
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    // Metastability filter chain
    always_ff @(posedge clk) begin
        if (reset) begin
            r_meta <= {WIDTH{1'b1}};
            r_sync <= {WIDTH{1'b1}};
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
        end
    end

    assign o_sync = r_sync;

endmodule

// File: rtl/keypad_scanner.sv
// Column-scanning 4x4 keypad reader with press/release debounce; one key_valid strobe per press.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV       = 4,
    parameter int DEBOUNCE_SCANS = 3
) (
    input  logic       clk,
    input  logic       reset,
    output logic [3:0] col_drive,
    input  logic [3:0] row_sense,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held
);

    localparam int SLOT_W = $clog2(SCAN_DIV);
    localparam int CNT_W  = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0]  CNT_DONE  = CNT_W'(DEBOUNCE_SCANS);
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);

    logic [SLOT_W-1:0] r_slot;
    logic [1:0]        r_col;
    logic [3:0]        r_col_drive;
    logic [11:0]       r_hits;
    kp_state_t         r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [3:0]        r_cand;
    logic [3:0]        r_key_code;
    logic              r_key_valid;
    logic              r_key_held;

    logic [3:0]        w_rows_sync;
    logic [3:0]        w_pressed_now;
    logic              w_sample;
    logic              w_eval;
    logic [1:0]        w_next_col;
    logic [4:0]        w_count;
    logic [3:0]        w_code;
    scan_kind_t        w_kind;
    kp_state_t         w_state_next;
    logic [CNT_W-1:0]  w_cnt_next;
    logic [CNT_W-1:0]  w_cnt_inc;
    logic [3:0]        w_cand_next;
    logic              w_fire;

    keypad_sync #(.WIDTH(4)) u_sync (
        .clk     (clk),
        .reset   (reset),
        .i_async (row_sense),
        .o_sync  (w_rows_sync)
    );

    assign w_pressed_now = ~w_rows_sync;
    assign w_sample      = (r_slot == SLOT_LAST);
    assign w_eval        = w_sample && (r_col == 2'd3);
    assign w_next_col    = r_col + 2'd1;
    assign w_cnt_inc     = r_cnt + CNT_ONE;

    // Slot counter, column rotation and per-column row capture
    always_ff @(posedge clk) begin
        if (reset) begin
            r_slot      <= '0;
            r_col       <= 2'd0;
            r_col_drive <= 4'b1110;
            r_hits      <= 12'h000;
        end else if (w_sample) begin
            r_slot      <= '0;
            r_col       <= w_next_col;
            r_col_drive <= ~(4'b0001 << w_next_col);
            case (r_col)
                2'd0:    r_hits[3:0]  <= w_pressed_now;
                2'd1:    r_hits[7:4]  <= w_pressed_now;
                2'd2:    r_hits[11:8] <= w_pressed_now;
                default: r_hits       <= r_hits;
            endcase
        end else begin
            r_slot <= r_slot + SLOT_W'(1);
        end
    end

    // Classify the full scan; column 3 is taken live since this is its sampling edge
    always_comb begin
        w_count = 5'd0;
        w_code  = 4'h0;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if ((c == 3) ? w_pressed_now[r] : r_hits[c*4 + r]) begin
                    w_count = w_count + 5'd1;
                    w_code  = row_col_to_code(2'(r), 2'(c));
                end else begin
                    w_count = w_count;
                end
            end
        end
        if (w_count == 5'd0) begin
            w_kind = SCAN_NONE;
        end else if (w_count == 5'd1) begin
            w_kind = SCAN_SINGLE;
        end else begin
            w_kind = SCAN_MULTI;
        end
    end

    // Debounce FSM next-state; it only moves on scan evaluation edges
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_cand_next  = r_cand;
        w_fire       = 1'b0;
        if (w_eval) begin
            case (r_state)
                IDLE: begin
                    if (w_kind == SCAN_SINGLE) begin
                        w_cand_next = w_code;
                        w_cnt_next  = CNT_ONE;
                        if (CNT_ONE == CNT_DONE) begin
                            w_state_next = PRESSED;
                            w_fire       = 1'b1;
                        end else begin
                            w_state_next = DEBOUNCE;
                        end
                    end else begin
                        w_state_next = IDLE;
                    end
                end
                DEBOUNCE: begin
                    if (w_kind == SCAN_SINGLE && w_code == r_cand) begin
                        w_cnt_next = w_cnt_inc;
                        if (w_cnt_inc == CNT_DONE) begin
                            w_state_next = PRESSED;
                            w_fire       = 1'b1;
                        end else begin
                            w_state_next = DEBOUNCE;
                        end
                    end else if (w_kind == SCAN_SINGLE) begin
                        w_cand_next = w_code;
                        w_cnt_next  = CNT_ONE;
                    end else begin
                        w_state_next = IDLE;
                        w_cnt_next   = '0;
                    end
                end
                PRESSED: begin
                    if (w_kind == SCAN_NONE) begin
                        w_cnt_next   = CNT_ONE;
                        w_state_next = (CNT_ONE == CNT_DONE) ? IDLE : RELEASE;
                    end else begin
                        w_state_next = PRESSED;
                    end
                end
                RELEASE: begin
                    // Any key seen mid-release is treated as bounce: back to PRESSED, no strobe
                    if (w_kind == SCAN_NONE) begin
                        w_cnt_next   = w_cnt_inc;
                        w_state_next = (w_cnt_inc == CNT_DONE) ? IDLE : RELEASE;
                    end else begin
                        w_state_next = PRESSED;
                    end
                end
                default: begin
                    w_state_next = IDLE;
                    w_cnt_next   = '0;
                end
            endcase
        end else begin
            w_state_next = r_state;
        end
    end

    // FSM state and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_cand      <= 4'h0;
            r_key_code  <= 4'h0;
            r_key_valid <= 1'b0;
            r_key_held  <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_cnt       <= w_cnt_next;
            r_cand      <= w_cand_next;
            r_key_code  <= w_fire ? w_cand_next : r_key_code;
            r_key_valid <= w_fire;
            r_key_held  <= (w_state_next == PRESSED) || (w_state_next == RELEASE);
        end
    end

    assign col_drive = r_col_drive;
    assign key_code  = r_key_code;
    assign key_valid = r_key_valid;
    assign key_held  = r_key_held;

endmodule
